coin_input_conditioner: RTL and testbench

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

---
 rtl/coin_input_conditioner.sv | 212 +++++++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//   Debounces the player fire/start/coin inputs taken from packed joystick
//   words. It drives registered active-low fire/start to the game core and
//   turns each debounced coin press into a fixed-length low pulse on coin_n,
//   followed by an equal-length high gap. Up to three presses that arrive
//   while a pulse is running are queued.
//
//   Optional feature macro: COIN_INPUT_AUTOFIRE_EN. When it is defined, the
//   autofire_en port exists and a held fire toggles fire_n every AF_PERIOD
//   cycles.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   joy          in   16*NPLAYERS packed words (bit4 fire, bit5 start,
//                     bit6 select, bit7 coin)
//   autofire_en  in   NPLAYERS per-player autofire enable (macro builds only)
//   fire_n       out  NPLAYERS active-low fire
//   start_n      out  NPLAYERS active-low start (P1 select also starts P2)
//   coin_n       out  active-low stretched coin pulse
//   coin_count   out  8-bit wrapping count of coin pulses issued
//   coin_busy    out  coin sequencer not idle
//
// Coin FSM
//   state   | meaning
//   S_IDLE  | waiting for a coin press
//   S_PULSE | coin_n held low for COIN_PULSE cycles
//   S_GAP   | coin_n held high for COIN_PULSE cycles before the next pulse
module coin_input_conditioner #(
  parameter int NPLAYERS   = 2,
  parameter int DEB_CYCLES = 16,
  parameter int COIN_PULSE = 4096,
  parameter int AF_PERIOD  = 1024
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [16*NPLAYERS-1:0] joy,
`ifdef COIN_INPUT_AUTOFIRE_EN
  input  logic [NPLAYERS-1:0]    autofire_en,
`endif
  output logic [NPLAYERS-1:0]    fire_n,
  output logic [NPLAYERS-1:0]    start_n,
  output logic                   coin_n,
  output logic [7:0]             coin_count,
  output logic                   coin_busy
);

  // Raw signal order: fire[0..N-1], start[0..N-1], coin.
  localparam int NRAW     = 2*NPLAYERS + 1;
  localparam int COIN_IDX = 2*NPLAYERS;
  localparam int DW       = $clog2(DEB_CYCLES + 1);
  localparam int PMAX     = (COIN_PULSE > AF_PERIOD) ? COIN_PULSE : AF_PERIOD;
  localparam int PW       = $clog2(PMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PH_LOAD  = PW'(COIN_PULSE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [NRAW-1:0] raw;
  logic [NRAW-1:0] deb;
  logic            coin_any;
  logic            unused_joy;

  // Only bits 4..7 of each word are used.
  assign unused_joy = ^joy;

  always_comb begin
    raw      = '0;
    coin_any = 1'b0;
    for (int p = 0; p < NPLAYERS; p++) begin
      raw[p]            = joy[16*p+4];
      raw[NPLAYERS + p] = joy[16*p+5];
      coin_any          = coin_any | joy[16*p+7];
    end
    // Player 1 select doubles as player 2 start.
    if (NPLAYERS >= 2) raw[NPLAYERS+1] = raw[NPLAYERS+1] | joy[6];
    raw[COIN_IDX] = coin_any;
  end

  // Debouncers: the counter runs only while raw disagrees with deb, so a
  // glitch shorter than DEB_CYCLES resets it and never flips deb.
  for (genvar i = 0; i < NRAW; i++) begin : g_deb
    logic          d_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        d_q <= 1'b0;
        cnt <= '0;
      end else if (raw[i] == d_q) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        d_q <= raw[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = d_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) start_n <= '1;
    else       start_n <= ~deb[2*NPLAYERS-1:NPLAYERS];
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_fire
`ifdef COIN_INPUT_AUTOFIRE_EN
    localparam logic [PW-1:0] AF_LOAD = PW'(AF_PERIOD - 1);
    logic          f_q;
    logic          af_active;
    logic [PW-1:0] af_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        f_q       <= 1'b1;
        af_active <= 1'b0;
        af_cnt    <= '0;
      end else if (!deb[p]) begin
        f_q       <= 1'b1;
        af_active <= 1'b0;
        af_cnt    <= '0;
      end else if (!autofire_en[p]) begin
        f_q       <= 1'b0;
        af_active <= 1'b0;
        af_cnt    <= '0;
      end else if (!af_active) begin
        // First cycle of a held fire always starts with a low half-period.
        f_q       <= 1'b0;
        af_active <= 1'b1;
        af_cnt    <= AF_LOAD;
      end else if (af_cnt == '0) begin
        f_q    <= ~f_q;
        af_cnt <= AF_LOAD;
      end else begin
        af_cnt <= af_cnt - 1'b1;
      end
    end
`else
    logic f_q;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) f_q <= 1'b1;
      else       f_q <= ~deb[p];
    end
`endif
    assign fire_n[p] = f_q;
  end

  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [1:0]    pending;
  logic          deb_coin_q;
  logic          coin_event;

  assign coin_event = deb[COIN_IDX] & ~deb_coin_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      pending    <= '0;
      coin_count <= '0;
      deb_coin_q <= 1'b0;
    end else begin
      deb_coin_q <= deb[COIN_IDX];
      case (state)
        S_IDLE: begin
          if (coin_event) begin
            state      <= S_PULSE;
            phase      <= PH_LOAD;
            coin_count <= coin_count + 8'd1;
          end
        end
        S_PULSE: begin
          if (coin_event && pending != 2'd3) pending <= pending + 2'd1;
          if (phase == '0) begin
            state <= S_GAP;
            phase <= PH_LOAD;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_GAP: begin
          if (phase != '0) begin
            phase <= phase - 1'b1;
            if (coin_event && pending != 2'd3) pending <= pending + 2'd1;
          end else if (pending != 2'd0 || coin_event) begin
            // A press landing on the gap's last edge takes the place of the
            // queued one being consumed, so pending stays put.
            state      <= S_PULSE;
            phase      <= PH_LOAD;
            coin_count <= coin_count + 8'd1;
            if (!coin_event) pending <= pending - 2'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset releases coin_n without a clock.
  assign coin_n    = (state != S_PULSE);
  assign coin_busy = (state != S_IDLE);

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

  localparam int NP  = 2;
  localparam int DEB = 4;
  localparam int CP  = 8;
  localparam int AF  = 4;
  localparam int NR  = 2*NP + 1;
`ifdef COIN_INPUT_AUTOFIRE_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic            clk_sys = 1'b0;
  logic            reset   = 1'b1;
  logic [16*NP-1:0] joy    = '0;
  logic [NP-1:0]   autofire_en_tb = '0;
  logic [NP-1:0]   fire_n;
  logic [NP-1:0]   start_n;
  logic            coin_n;
  logic [7:0]      coin_count;
  logic            coin_busy;

  coin_input_conditioner #(
    .NPLAYERS  (NP),
    .DEB_CYCLES(DEB),
    .COIN_PULSE(CP),
    .AF_PERIOD (AF)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy        (joy),
`ifdef COIN_INPUT_AUTOFIRE_EN
    .autofire_en(autofire_en_tb),
`endif
    .fire_n     (fire_n),
    .start_n    (start_n),
    .coin_n     (coin_n),
    .coin_count (coin_count),
    .coin_busy  (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  // Reference model: debounced value flips once the last DEB samples all
  // disagree with it; coin pulses are kept as a list of start edges.
  logic [DEB-1:0] hist [NR];
  logic [NR-1:0]  deb_m;
  logic           deb_coin_prev;
  logic [NP-1:0]  fire_exp;
  logic [NP-1:0]  start_exp;
  int             starts[$];
  int             t = 0;
  int             af_k [NP];
  bit             af_run [NP];
  int             bl [7] = '{4, 5, 6, 7, 20, 21, 23};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic [NR-1:0] raw_of(input logic [31:0] j);
    logic [NR-1:0] r;
    r[0] = j[4];
    r[1] = j[20];
    r[2] = j[5];
    r[3] = j[21] | j[6];
    r[4] = j[7] | j[23];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) hist[i] = '0;
    deb_m         = '0;
    deb_coin_prev = 1'b0;
    fire_exp      = '1;
    start_exp     = '1;
    starts.delete();
    for (int p = 0; p < NP; p++) begin
      af_run[p] = 1'b0;
      af_k[p]   = 0;
    end
  endtask

  task automatic schedule();
    int n;
    if (starts.size() == 0 || t >= starts[$] + 2*CP) begin
      starts.push_back(t);
    end else begin
      n = 0;
      foreach (starts[k]) if (starts[k] > t) n++;
      if (n < 3) starts.push_back(starts[$] + 2*CP);
    end
  endtask

  task automatic model_edge();
    logic [NR-1:0] r;
    bit ev;
    r  = raw_of(joy);
    ev = deb_m[NR-1] && !deb_coin_prev;
    for (int p = 0; p < NP; p++) begin
      if (deb_m[p] && AF_ON && autofire_en_tb[p]) begin
        if (af_run[p]) af_k[p]++;
        else begin
          af_run[p] = 1'b1;
          af_k[p]   = 0;
        end
        fire_exp[p] = ((af_k[p] / AF) % 2) == 1;
      end else begin
        af_run[p]   = 1'b0;
        fire_exp[p] = ~deb_m[p];
      end
    end
    start_exp     = ~deb_m[2*NP-1:NP];
    deb_coin_prev = deb_m[NR-1];
    for (int i = 0; i < NR; i++) begin
      hist[i] = {hist[i][DEB-2:0], r[i]};
      if (hist[i] == {DEB{~deb_m[i]}}) deb_m[i] = ~deb_m[i];
    end
    if (ev) schedule();
  endtask

  function automatic logic exp_coin_n();
    foreach (starts[k]) if (starts[k] <= t && t < starts[k] + CP) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    foreach (starts[k]) if (starts[k] <= t && t < starts[k] + 2*CP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_count();
    int n;
    n = 0;
    foreach (starts[k]) if (starts[k] <= t) n++;
    return 8'(n);
  endfunction

  task automatic check_all();
    chk("fire_n", fire_n, fire_exp);
    chk("start_n", start_n, start_exp);
    chk("coin_n", coin_n, exp_coin_n());
    chk("coin_busy", coin_busy, exp_busy());
    chk("coin_count", coin_count, exp_count());
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!reset) begin
      t++;
      model_edge();
    end
    #1;
    check_all();
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (coin_busy && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_timeout", coin_busy, 1'b0);
  endtask

  task automatic press(input int b);
    joy[b] = 1'b1;
    repeat (DEB) tick();
    joy[b] = 1'b0;
    repeat (DEB) tick();
  endtask

  initial begin
    logic [7:0]  c0;
    logic [7:0]  dlt;
    logic [11:0] pat;
    int lo, busy, n;

    model_reset();
    reset = 1'b1;
    joy   = '0;
    repeat (3) tick();
    chk("rst_fire_n", fire_n, 2'b11);
    chk("rst_start_n", start_n, 2'b11);
    chk("rst_coin_n", coin_n, 1'b1);
    chk("rst_coin_count", coin_count, 8'd0);
    chk("rst_coin_busy", coin_busy, 1'b0);
    @(negedge clk_sys) reset = 1'b0;

    // Short glitch on fire never reaches the output.
    joy[4] = 1'b1;
    repeat (3) tick();
    joy[4] = 1'b0;
    repeat (8) tick();
    chk("glitch_fire_n", fire_n, 2'b11);

    // Five-edge latency on player 2 fire and on select-as-start.
    joy[20] = 1'b1;
    repeat (4) tick();
    chk("fire1_edge4", fire_n[1], 1'b1);
    tick();
    chk("fire1_edge5", fire_n[1], 1'b0);
    joy[6] = 1'b1;
    repeat (4) tick();
    chk("start1_edge4", start_n[1], 1'b1);
    tick();
    chk("start1_edge5", start_n[1], 1'b0);
    joy = '0;
    repeat (10) tick();
    chk("released", {fire_n, start_n}, 4'b1111);

    // One long coin press gives exactly one pulse.
    c0   = coin_count;
    lo   = 0;
    busy = 0;
    joy[7] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) joy[7] = 1'b0;
      tick();
      if (!coin_n) lo++;
      if (coin_busy) busy++;
    end
    chk("single_low_cycles", lo, 8);
    chk("single_busy_cycles", busy, 16);
    dlt = coin_count - c0;
    chk("single_count", dlt, 8'd1);

    // Three quick presses are all queued and issued.
    c0 = coin_count;
    for (int k = 0; k < 3; k++) press((k % 2 == 0) ? 7 : 23);
    wait_idle(300);
    dlt = coin_count - c0;
    chk("burst3_count", dlt, 8'd3);

    // Eight quick presses: pending saturates and one press is dropped.
    c0 = coin_count;
    for (int k = 0; k < 8; k++) press((k % 2 == 0) ? 23 : 7);
    wait_idle(400);
    dlt = coin_count - c0;
    chk("burst8_count", dlt, 8'd7);

    // Reset in the middle of a pulse releases coin_n without a clock.
    joy[7] = 1'b1;
    n = 0;
    while (coin_n && n < 30) begin
      tick();
      n++;
    end
    chk("pulse_seen", coin_n, 1'b0);
    repeat (3) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_coin_n", coin_n, 1'b1);
    chk("async_coin_busy", coin_busy, 1'b0);
    chk("async_coin_count", coin_count, 8'd0);
    repeat (2) tick();
    @(negedge clk_sys) reset = 1'b0;
    tick();
    chk("post_rst_count", coin_count, 8'd0);
    chk("post_rst_busy", coin_busy, 1'b0);
    repeat (30) tick();
    chk("held_coin_count", coin_count, 8'd1);
    joy = '0;
    repeat (6) tick();
    wait_idle(100);

    // Random activity on the used bits plus occasional noise elsewhere.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 8);
        if (n < 7) joy[bl[n]] = ~joy[bl[n]];
        else begin
          n = $urandom_range(0, 31);
          joy[n] = ~joy[n];
        end
      end
      tick();
    end
    joy = '0;
    repeat (8) tick();
    wait_idle(500);

`ifdef COIN_INPUT_AUTOFIRE_EN
    autofire_en_tb = 2'b01;
    repeat (6) tick();
    joy[4] = 1'b1;
    n = 0;
    while (fire_n[0] && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      pat[11-i] = fire_n[0];
      tick();
    end
    chk("af_pattern", pat, 12'b000011110000);
    joy[4] = 1'b0;
    repeat (DEB + 1) tick();
    chk("af_release", fire_n[0], 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
